// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter: grant select
// encoding, data width and conflict counter width.
package wb_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    // Grant select; the encoding doubles as the data mux select bit.
    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } gnt_sel_e;

endpackage

// File: rtl/mux_64_2_1.sv
// 64-bit 2:1 data select; sel=1 picks in1.
module mux_64_2_1
    import wb_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              sel,
    output logic [DATA_W-1:0] out
);

    // Pure combinational select.
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester write-back arbiter feeding a single registered register-file
// write port. Requester 0 is the ALU result, requester 1 the load result.
// Config macro WB_ARB_ROUND_ROBIN_EN: when defined, ties alternate using a
// last-grant flop (requester 0 wins the first tie after reset); when
// undefined, ties always go to requester 1 and no last-grant state exists.
//
// Handshake: a transfer happens on requester N at a rising edge where
// reqN_valid and reqN_ready are both high; the output write is consumed at
// an edge where out_valid and out_ready are both high. reqN_ready never
// depends on out_valid being dropped by the consumer in the same cycle
// beyond load = !out_valid | out_ready, and at most one ready is high.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    gnt_sel_e          gnt;
    logic              gnt_valid;
    logic              load;
    logic              accept;
    logic              write_real;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
    gnt_sel_e          last_grant_q, last_grant_d;
`endif

    // Grant selection: single requester wins outright; ties resolved by config.
    always_comb begin
        gnt       = GNT_REQ0;
        gnt_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            gnt = (last_grant_q == GNT_REQ0) ? GNT_REQ1 : GNT_REQ0;
`else
            gnt = GNT_REQ1;
`endif
        end else if (req1_valid) begin
            gnt = GNT_REQ1;
        end
    end

    // The only data path from requesters to the output register.
    mux_64_2_1 u_data_mux (
        .in0 (req0_data),
        .in1 (req1_data),
        .sel (gnt == GNT_REQ1),
        .out (sel_data)
    );

    // Handshake and next-state computation for the output register and counter.
    always_comb begin
        load       = !out_valid_q || out_ready;
        accept     = load && gnt_valid && !reset;
        req0_ready = accept && (gnt == GNT_REQ0);
        req1_ready = accept && (gnt == GNT_REQ1);
        sel_addr   = (gnt == GNT_REQ1) ? req1_addr : req0_addr;
        // Writes to the hardwired-zero register handshake but never reach the file.
        write_real = accept && (sel_addr != ZERO_ADDR);

        out_valid_d    = out_valid_q;
        out_addr_d     = out_addr_q;
        out_data_d     = out_data_q;
        conflict_cnt_d = conflict_cnt_q;

        if (load) begin
            out_valid_d = write_real;
        end
        if (write_real) begin
            out_addr_d = sel_addr;
            out_data_d = sel_data;
        end
        if (req0_valid && req1_valid && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
`ifdef WB_ARB_ROUND_ROBIN_EN
        last_grant_d = accept ? gnt : last_grant_q;
`endif
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            conflict_cnt_q <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_q   <= GNT_REQ1;
`endif
        end else begin
            out_valid_q    <= out_valid_d;
            out_addr_q     <= out_addr_d;
            out_data_q     <= out_data_d;
            conflict_cnt_q <= conflict_cnt_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; tie expectations follow the
// WB_ARB_ROUND_ROBIN_EN setting of the build.
module tb_wb_port_arbiter;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [63:0] req1_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [63:0] out_data;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.ADDR_W(5), .ZERO_REG(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .conflict_cnt (conflict_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h2;
        out_ready  = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 5'd0) begin errors++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h1111;
        out_ready  = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_addr !== 5'd3) begin errors++; $display("FAIL single_addr: got %0d expected 3", out_addr); end
        checks++; if (out_data !== 64'h1111) begin errors++; $display("FAIL single_data: got %h expected 1111", out_data); end
        tick();
        // Idle with load high: valid drops, address/data hold.
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 64'h1111) begin errors++; $display("FAIL idle_data_hold: got %h expected 1111", out_data); end
    endtask

    task automatic test_tie();
        bit exp_g;
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hA0A0;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 64'hB1B1;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = RR ? bit'(i % 2) : 1'b1;
            #1;
            checks++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin errors++; $display("FAIL tie_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, {~exp_g, exp_g}); end
            tick();
            checks++; if (out_data !== (exp_g ? 64'hB1B1 : 64'hA0A0)) begin errors++; $display("FAIL tie_data[%0d]: got %h expected %h", i, out_data, exp_g ? 64'hB1B1 : 64'hA0A0); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL tie_cnt: got %0d expected 4", conflict_cnt); end
    endtask

    task automatic test_stall();
        bit exp_g;
        do_reset();
        // Load from requester 1 so the round-robin last grant is 1.
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'h77;
        out_ready  = 1'b1;
        tick();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hA0A0;
        req1_addr  = 5'd6; req1_data = 64'hB1B1;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready}); end
            tick();
            checks++; if ({out_valid, out_addr, out_data} !== {1'b1, 5'd7, 64'h77}) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%0d/%h expected 1/7/77", i, out_valid, out_addr, out_data); end
        end
        checks++; if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", conflict_cnt); end
        out_ready = 1'b1;
        exp_g = RR ? 1'b0 : 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin errors++; $display("FAIL after_stall_ready: got %b expected %b", {req0_ready, req1_ready}, {~exp_g, exp_g}); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (out_addr !== (exp_g ? 5'd6 : 5'd5)) begin errors++; $display("FAIL after_stall_addr: got %0d expected %0d", out_addr, exp_g ? 5'd6 : 5'd5); end
        checks++; if (conflict_cnt !== 16'd4) begin errors++; $display("FAIL after_stall_cnt: got %0d expected 4", conflict_cnt); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'hDEAD;
        out_ready  = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL zero_ready: got %b expected 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 64'h1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 64'h2;
        out_ready  = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", conflict_cnt); end
        tick();
        checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h expected ffff", conflict_cnt); end
        for (int i = 0; i < 4465; i++) @(posedge clk);
        #1;
        checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", conflict_cnt); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 64'h99;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 64'hAA;
        out_ready  = 1'b1;
        tick();
        req1_valid = 1'b0;
        out_ready  = 1'b0;
        #1;
        checks++; if ({out_valid, conflict_cnt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL pre_async: got %b/%0d expected 1/1", out_valid, conflict_cnt); end
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        checks++; if ({out_valid, out_addr, out_data, conflict_cnt} !== {1'b0, 5'd0, 64'h0, 16'd0}) begin errors++; $display("FAIL async_clear: got %b/%0d/%h/%0d expected 0/0/0/0", out_valid, out_addr, out_data, conflict_cnt); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL async_ready: got %b expected 00", {req0_ready, req1_ready}); end
        tick();
        reset      = 1'b0;
        req0_valid = 1'b0;
    endtask

    // Test sequence
    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        out_ready  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_tie();
        test_stall();
        test_zero_reg();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
